// File: rtl/muldiv_ctl_pkg.sv
// Shared state encodings, step counts and helpers for the mul/div sequencer.
// No logic; constants and pure functions only.
// Imported by muldiv_ctl.
package muldiv_ctl_pkg;

  typedef enum logic [1:0] {
    MDIDLE = 2'd0,
    MDRUN  = 2'd1,
    MDFIX  = 2'd2
  } md_state_t;

  localparam logic [6:0] MDWORDSTEPS  = 7'd32;
  localparam logic [6:0] MDDWORDSTEPS = 7'd64;

  // Sign-extend a word result to the 64-bit datapath
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_ctl.sv
// Iterative radix-2 multiply / restoring divide sequencer owning HI/LO.
// Latency: start edge + N step edges + 1 fix edge; done visible 34 (word) / 66 (dword) cycles after start.
// No backpressure: busy interlocks issue; start while busy is ignored, kill aborts without writing HI/LO.
module muldiv_ctl
  import muldiv_ctl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        isdiv,
  input  logic        dword,
  input  logic        sgn,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        kill,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [63:0] hi,
  output logic [63:0] lo
);

  md_state_t    state;
  logic [6:0]   cnt;
  logic [127:0] acc;      // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [63:0]  opb;      // |multiplicand| or |divisor|
  logic         op_div;
  logic         op_dw;
  logic         neg_q;    // product / quotient sign
  logic         neg_r;    // remainder sign (dividend sign)
  logic         div0;

  // Operand preparation at issue: magnitudes, signs, initial accumulator
  logic         a_neg, b_neg, b_zero;
  logic [31:0]  a_abs32, b_abs32;
  logic [63:0]  a_abs, b_abs;
  logic [127:0] acc_init;

  // Operand sign/magnitude and initial accumulator layout
  always_comb begin
    a_neg   = sgn & (dword ? a[63] : a[31]);
    b_neg   = sgn & (dword ? b[63] : b[31]);
    a_abs32 = a_neg ? (32'd0 - a[31:0]) : a[31:0];
    b_abs32 = b_neg ? (32'd0 - b[31:0]) : b[31:0];
    a_abs   = dword ? (a_neg ? (64'd0 - a) : a) : {32'd0, a_abs32};
    b_abs   = dword ? (b_neg ? (64'd0 - b) : b) : {32'd0, b_abs32};
    b_zero  = dword ? (b == 64'd0) : (b[31:0] == 32'd0);
    // A word dividend sits at the top of the low half so 32 left shifts consume it
    if (isdiv && !dword) acc_init = {64'd0, a_abs[31:0], 32'd0};
    else                 acc_init = {64'd0, a_abs};
  end

  // One shared adder: add multiplicand (mul) or subtract divisor from the shifted remainder (div)
  logic [65:0]  add_x, add_y, add_sum;
  logic [127:0] acc_step;

  // Single radix-2 step for the current operation
  always_comb begin
    add_x   = op_div ? {1'b0, acc[127:63]} : {2'b0, acc[127:64]};
    add_y   = op_div ? ~{2'b0, opb}        : {2'b0, opb};
    add_sum = add_x + add_y + {65'd0, op_div};
    if (op_div) begin
      // Negative trial difference: restore by keeping the plain shift
      if (add_sum[65]) acc_step = {acc[126:0], 1'b0};
      else             acc_step = {add_sum[63:0], acc[62:0], 1'b1};
    end else begin
      if (acc[0]) acc_step = {add_sum[64:0], acc[63:1]};
      else        acc_step = {1'b0, acc[127:1]};
    end
  end

  // Sign correction and HI/LO formatting for the finished operation
  logic [127:0] p_dw;
  logic [63:0]  p_wd, q_s, r_s;
  logic [63:0]  fix_hi, fix_lo;

  // Result formatting in the FIX cycle
  always_comb begin
    p_dw = neg_q ? (128'd0 - acc) : acc;
    // After 32 steps the word product sits one half-word up in the accumulator
    p_wd = neg_q ? (64'd0 - acc[95:32]) : acc[95:32];
    q_s  = neg_q ? (64'd0 - acc[63:0])  : acc[63:0];
    r_s  = neg_r ? (64'd0 - acc[127:64]) : acc[127:64];
    if (!op_div) begin
      fix_lo = op_dw ? p_dw[63:0]   : sext32(p_wd[31:0]);
      fix_hi = op_dw ? p_dw[127:64] : sext32(p_wd[63:32]);
    end else begin
      fix_lo = op_dw ? q_s : sext32(q_s[31:0]);
      fix_hi = op_dw ? r_s : sext32(r_s[31:0]);
      // Zero divisor: the restoring steps already leave |dividend| as remainder,
      // only the quotient needs forcing
      if (div0) fix_lo = '1;
    end
  end

  // Sequencer FSM with registered busy/done and HI/LO ownership
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= MDIDLE;
      cnt    <= 7'd0;
      acc    <= '0;
      opb    <= '0;
      op_div <= 1'b0;
      op_dw  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MDIDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !kill) begin
            state  <= MDRUN;
            busy   <= 1'b1;
            cnt    <= dword ? MDDWORDSTEPS : MDWORDSTEPS;
            acc    <= acc_init;
            opb    <= b_abs;
            op_div <= isdiv;
            op_dw  <= dword;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= isdiv & b_zero;
          end
        end
        MDRUN: begin
          if (kill) begin
            state <= MDIDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_step;
            cnt <= cnt - 7'd1;
            if (cnt == 7'd1) state <= MDFIX;
          end
        end
        MDFIX: begin
          state <= MDIDLE;
          busy  <= 1'b0;
          if (!kill) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= MDIDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
